// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the parameterised synchronous FIFO.
// Latency: none (compile-time only).
// Backpressure: n/a.
package fifo_pkg;

    // Read-side presentation modes
    localparam int FWFT_OFF = 0;  // registered read: word appears the cycle after the pop
    localparam int FWFT_ON  = 1;  // first-word-fall-through: head word always visible

    // Occupancy counter width: one extra bit so a completely full FIFO is representable
    function automatic int cnt_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Push/pop bus and status flags between a FIFO and its user.
// Latency: none (wires only).
// Backpressure: user must honour full/empty; violations raise sticky overflow/underflow.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
);
    localparam int CW = cnt_width(DEPTH_LOG2);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    // User side: drives requests, observes data and flags
    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; caller guarantees only legal writes are issued.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [2**AW];

    // Write port; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with occupancy flags, sticky errors and optional FWFT.
// Latency: FWFT=0 pop data one cycle after the pop edge; FWFT=1 first word one cycle after push.
// Backpressure: push ignored while full (overflow), pop ignored while empty (underflow).
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6,
    parameter int AF_LEVEL   = 2**DEPTH_LOG2 - 4,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic clk,
    input  logic rst,
    sync_fifo_param_if.slave bus
);

    localparam int AW    = DEPTH_LOG2;
    localparam int CW    = cnt_width(DEPTH_LOG2);
    localparam int DEPTH = 2**DEPTH_LOG2;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Thresholds must be ordered and fit inside the storage
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $fatal(1, "sync_fifo_param: need AE_LEVEL < AF_LEVEL <= 2**DEPTH_LOG2");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic             empty, full;
    logic             push_ok, pop_ok;
    logic             ram_we;
    logic [WIDTH-1:0] ram_rdata;

    // Flags decode straight from the registered count
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign push_ok = bus.wr_en && !full;
    assign pop_ok  = bus.rd_en && !empty;
    assign ram_we  = push_ok && !bus.flush;

    // Pointer, occupancy and sticky-error next state; flush overrides everything
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CW'(1);
            end
            if (bus.wr_en && full) begin
                overflow_d = 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        // Head word is always on the output; forced to zero while nothing is stored
        assign bus.rd_valid = !empty;
        assign bus.rd_data  = empty ? '0 : ram_rdata;
    end else begin : g_reg_read
        logic [WIDTH-1:0] rd_data_q, rd_data_d;
        logic             rd_valid_q, rd_valid_d;

        // Capture the head word on an accepted pop; hold it otherwise (flush keeps data)
        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
            if (!bus.flush && pop_ok) begin
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
            end
        end

        // Read output registers
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal 1..64.
REQ-002 Parameter DEPTH_LOG2, default 6: depth = 2**DEPTH_LOG2 words, legal 1..12.
REQ-003 Parameter AF_LEVEL, default 2**DEPTH_LOG2-4: almost_full threshold in words.
REQ-004 Parameter AE_LEVEL, default 4: almost_empty threshold in words.
REQ-005 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low.
REQ-008 flush  input  1  synchronous clear of contents and flags.
REQ-009 wr_en  input  1  push request.
REQ-010 wr_data  input  WIDTH  word to push.
REQ-011 rd_en  input  1  pop request.
REQ-012 rd_data  output  WIDTH  read word.
REQ-013 rd_valid  output  1  rd_data holds a word popped or presented this cycle.
REQ-014 empty, full, almost_empty, almost_full  output  1 each  occupancy flags.
REQ-015 count  output  DEPTH_LOG2+1  words stored, 0..2**DEPTH_LOG2.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Push accepted iff wr_en && !full, evaluated on registered full before the edge; accepted word written at wr_ptr, wr_ptr increments modulo depth.
REQ-018 Pop accepted iff rd_en && !empty, evaluated on registered empty before the edge; rd_ptr increments modulo depth.
REQ-019 Accepted push and pop in same cycle: count unchanged, both pointers advance.
REQ-020 Push while full: word discarded, no state change except overflow set to 1; a same-cycle pop still proceeds.
REQ-021 Pop while empty: no state change except underflow set to 1 (FWFT=0 and FWFT=1 alike); a same-cycle push still proceeds.
REQ-022 empty = (count==0); full = (count==2**DEPTH_LOG2); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all decoded from registered count, no added latency.
REQ-023 FWFT=0: accepted pop loads mem[rd_ptr] into rd_data at that edge, rd_valid=1 for exactly the following cycle; rd_data holds its value otherwise.
REQ-024 FWFT=1: rd_data = mem[rd_ptr] and rd_valid = !empty every cycle; first word written into an empty FIFO appears the cycle after its push edge; pop advances to next word at the edge.
REQ-025 flush has priority over wr_en and rd_en: pointers, count, overflow, underflow cleared to 0, rd_valid=0; memory contents and FWFT=0 rd_data not cleared.
REQ-026 Pointer wrap: 2**DEPTH_LOG2 consecutive push/pop pairs return pointers to 0 with data order preserved.
REQ-027 Parameter check at elaboration: AE_LEVEL < AF_LEVEL <= 2**DEPTH_LOG2, else fatal error.

Reset
REQ-028 rst low asynchronously forces wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow, underflow to 0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Memory array is not reset; reset mid-operation discards all stored words; release is synchronous to clk, first push accepted at first edge after release.

Structure
REQ-030 Package fifo_pkg holds the count/pointer width function and the FWFT mode constants.
REQ-031 Storage in one sub-module fifo_ram: simple dual-port, one synchronous write port, one asynchronous read port, WIDTH x 2**DEPTH_LOG2, no reset.

Verification (WIDTH=8, DEPTH_LOG2=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 Push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full at 4; fifth push 0x55 sets overflow, count stays 4.
REQ-033 FWFT=0, pop 4 from full -> rd_data 0x11,0x22,0x33,0x44 each with rd_valid one cycle after pop; empty at count 0; extra pop sets underflow.
REQ-034 FWFT=1, push 0xA5 into empty -> next cycle rd_data=0xA5, rd_valid=1; pop -> empty=1, rd_valid=0 next cycle.
REQ-035 Full FIFO, wr_en and rd_en same cycle -> pop accepted, push 0x99 rejected, overflow=1, count 3.
REQ-036 Count=2 with wr_en=rd_en=flush=1 -> next cycle count 0, empty=1, overflow=underflow=0; 10 push/pop pairs afterward return data in order across pointer wrap.
REQ-037 Assert rst low mid-burst at count 3 -> same cycle count 0, empty=1, rd_valid=0, flags cleared, without a clk edge.
